// File: rtl/cpu_pkg.sv
// Shared CPU definitions: data memory geometry defaults, the requester
// encoding used by the data memory arbiter, and word-address constants.
package cpu_pkg;

  localparam int unsigned DATA_WIDTH     = 32;
  localparam int unsigned ADDR_WIDTH     = 5;

  // Data memory is word addressed; byte address bits [1:0] select a byte lane.
  localparam int unsigned BYTE_OFFSET    = 2;
  localparam int unsigned BYTES_PER_WORD = 32'(1) << BYTE_OFFSET;

  // Requester identity, used as the round-robin history bit.
  typedef enum logic {
    REQ_CPU = 1'b0,
    REQ_DBG = 1'b1
  } req_e;

endpackage : cpu_pkg

// File: rtl/data_spram.sv
// Single-port synchronous RAM with a registered read.
// Ports:
//   clk   - clock, all accesses on rising edge
//   we    - write enable: mem[addr] <= wd
//   re    - read enable: rd <= mem[addr]; rd holds when re is low
//   addr  - word address
//   wd    - write data
//   rd    - registered read data
// Contents and rd are not reset.
module data_spram #(
  parameter int unsigned DATA_WIDTH = cpu_pkg::DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = cpu_pkg::ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wd,
  output logic [DATA_WIDTH-1:0] rd
);

  localparam int unsigned DEPTH = 32'(1) << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Write port and registered read port share the single address.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wd;
    end
    if (re) begin
      rd <= mem[addr];
    end
  end

endmodule : data_spram

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter sharing the single-port data memory between the CPU
// load/store path and the debug/loader port.
// Ports (cpu_* shown, dbg_* identical for the debug/loader requester):
//   clk, nreset         - clock, async active-low reset
//   cpu_req             - access request, held until granted
//   cpu_we              - 1 = write, 0 = read
//   cpu_addr, cpu_wd    - word address, write data
//   cpu_gnt             - access accepted this cycle (combinational)
//   cpu_stall           - cpu_req & ~cpu_gnt (CPU only)
//   cpu_rvalid, cpu_rd  - read data strobe and data, one cycle after grant
module data_mem_arbiter
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = cpu_pkg::DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = cpu_pkg::ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  nreset,

  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wd,
  output logic                  cpu_gnt,
  output logic                  cpu_stall,
  output logic                  cpu_rvalid,
  output logic [DATA_WIDTH-1:0] cpu_rd,

  input  logic                  dbg_req,
  input  logic                  dbg_we,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  input  logic [DATA_WIDTH-1:0] dbg_wd,
  output logic                  dbg_gnt,
  output logic                  dbg_rvalid,
  output logic [DATA_WIDTH-1:0] dbg_rd
);

  req_e                  last_grant;
  req_e                  last_grant_next;

  logic                  mem_we;
  logic                  mem_re;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wd;
  logic [DATA_WIDTH-1:0] mem_rd;

  logic [DATA_WIDTH-1:0] cpu_rd_q;
  logic [DATA_WIDTH-1:0] dbg_rd_q;

  // Round-robin history register.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      last_grant <= REQ_DBG;
    end else begin
      last_grant <= last_grant_next;
    end
  end

  // Grant decision: a lone requester always wins; on contention the one not
  // granted last wins. Grants are suppressed while reset is asserted.
  always_comb begin
    cpu_gnt         = 1'b0;
    dbg_gnt         = 1'b0;
    last_grant_next = last_grant;
    if (nreset) begin
      if (cpu_req && (!dbg_req || (last_grant == REQ_DBG))) begin
        cpu_gnt         = 1'b1;
        last_grant_next = REQ_CPU;
      end else if (dbg_req) begin
        dbg_gnt         = 1'b1;
        last_grant_next = REQ_DBG;
      end
    end
  end

  assign cpu_stall = cpu_req & ~cpu_gnt;

  // Steer the granted request into the RAM; nothing is enabled without a grant.
  always_comb begin
    mem_we   = 1'b0;
    mem_re   = 1'b0;
    mem_addr = cpu_addr;
    mem_wd   = cpu_wd;
    if (cpu_gnt) begin
      mem_we = cpu_we;
      mem_re = ~cpu_we;
    end else if (dbg_gnt) begin
      mem_we   = dbg_we;
      mem_re   = ~dbg_we;
      mem_addr = dbg_addr;
      mem_wd   = dbg_wd;
    end
  end

  data_spram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_data_spram (
    .clk  (clk),
    .we   (mem_we),
    .re   (mem_re),
    .addr (mem_addr),
    .wd   (mem_wd),
    .rd   (mem_rd)
  );

  // Read strobes: one cycle after a granted read, for that requester only.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      cpu_rvalid <= 1'b0;
      dbg_rvalid <= 1'b0;
    end else begin
      cpu_rvalid <= cpu_gnt & ~cpu_we;
      dbg_rvalid <= dbg_gnt & ~dbg_we;
    end
  end

  // The RAM read register is shared, so each requester keeps a copy of its
  // last returned word to hold its rd output across the other's reads.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      cpu_rd_q <= '0;
      dbg_rd_q <= '0;
    end else begin
      if (cpu_rvalid) begin
        cpu_rd_q <= mem_rd;
      end
      if (dbg_rvalid) begin
        dbg_rd_q <= mem_rd;
      end
    end
  end

  assign cpu_rd = cpu_rvalid ? mem_rd : cpu_rd_q;
  assign dbg_rd = dbg_rvalid ? mem_rd : dbg_rd_q;

endmodule : data_mem_arbiter

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: vector tables for grants, a shadow memory and
// per-requester read-data queues for the returned words.
module tb_data_mem_arbiter;

  localparam int unsigned DW = cpu_pkg::DATA_WIDTH;
  localparam int unsigned AW = cpu_pkg::ADDR_WIDTH;

  logic          clk = 1'b0;
  logic          nreset;
  logic          cpu_req, cpu_we, cpu_gnt, cpu_stall, cpu_rvalid;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wd, cpu_rd;
  logic          dbg_req, dbg_we, dbg_gnt, dbg_rvalid;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_wd, dbg_rd;

  always #5 clk = ~clk;

  data_mem_arbiter dut (
    .clk        (clk),
    .nreset     (nreset),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wd     (cpu_wd),
    .cpu_gnt    (cpu_gnt),
    .cpu_stall  (cpu_stall),
    .cpu_rvalid (cpu_rvalid),
    .cpu_rd     (cpu_rd),
    .dbg_req    (dbg_req),
    .dbg_we     (dbg_we),
    .dbg_addr   (dbg_addr),
    .dbg_wd     (dbg_wd),
    .dbg_gnt    (dbg_gnt),
    .dbg_rvalid (dbg_rvalid),
    .dbg_rd     (dbg_rd)
  );

  typedef struct {
    string         name;
    logic          c_req;
    logic          c_we;
    logic [AW-1:0] c_addr;
    logic [DW-1:0] c_wd;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wd;
    logic          e_cgnt;
    logic          e_dgnt;
  } vec_t;

  vec_t          vecs_a[$];
  vec_t          vecs_b[$];
  logic [DW-1:0] shadow [32'(1) << AW];
  logic [DW-1:0] cq[$];
  logic [DW-1:0] dq[$];
  logic          exp_c_rv, exp_d_rv;
  logic [DW-1:0] last_c_rd, last_d_rd;
  int            n_pass  = 0;
  int            n_total = 0;

  function automatic vec_t mk(input string name,
                              input logic c_req, input logic c_we,
                              input logic [AW-1:0] c_addr, input logic [DW-1:0] c_wd,
                              input logic d_req, input logic d_we,
                              input logic [AW-1:0] d_addr, input logic [DW-1:0] d_wd,
                              input logic e_cgnt, input logic e_dgnt);
    vec_t v;
    v.name   = name;
    v.c_req  = c_req;
    v.c_we   = c_we;
    v.c_addr = c_addr;
    v.c_wd   = c_wd;
    v.d_req  = d_req;
    v.d_we   = d_we;
    v.d_addr = d_addr;
    v.d_wd   = d_wd;
    v.e_cgnt = e_cgnt;
    v.e_dgnt = e_dgnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%h, want 0x%h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b, want %b (t=%0t)", name, act, exp, $time);
  endtask

  // Compare strobes/data owed from the previous cycle, then clear the debt.
  task automatic check_outputs(input string tag);
    logic [DW-1:0] e;
    chk1({tag, " cpu_rvalid"}, cpu_rvalid, exp_c_rv);
    if (cpu_rvalid === 1'b1) begin
      if (cq.size() == 0) chk1({tag, " cpu_rvalid_unexpected"}, cpu_rvalid, 1'b0);
      else begin
        e = cq.pop_front();
        chk({tag, " cpu_rd"}, cpu_rd, e);
        last_c_rd = e;
      end
    end else begin
      chk({tag, " cpu_rd_hold"}, cpu_rd, last_c_rd);
    end
    chk1({tag, " dbg_rvalid"}, dbg_rvalid, exp_d_rv);
    if (dbg_rvalid === 1'b1) begin
      if (dq.size() == 0) chk1({tag, " dbg_rvalid_unexpected"}, dbg_rvalid, 1'b0);
      else begin
        e = dq.pop_front();
        chk({tag, " dbg_rd"}, dbg_rd, e);
        last_d_rd = e;
      end
    end else begin
      chk({tag, " dbg_rd_hold"}, dbg_rd, last_d_rd);
    end
    exp_c_rv = 1'b0;
    exp_d_rv = 1'b0;
  endtask

  // Apply one vector for one cycle; called just after a rising edge.
  task automatic run_vec(input vec_t v);
    cpu_req  = v.c_req;
    cpu_we   = v.c_we;
    cpu_addr = v.c_addr;
    cpu_wd   = v.c_wd;
    dbg_req  = v.d_req;
    dbg_we   = v.d_we;
    dbg_addr = v.d_addr;
    dbg_wd   = v.d_wd;
    @(negedge clk);
    check_outputs(v.name);
    chk1({v.name, " cpu_gnt"}, cpu_gnt, v.e_cgnt);
    chk1({v.name, " dbg_gnt"}, dbg_gnt, v.e_dgnt);
    chk1({v.name, " cpu_stall"}, cpu_stall, v.c_req & ~v.e_cgnt);
    if (v.e_cgnt) begin
      if (v.c_we) shadow[v.c_addr] = v.c_wd;
      else begin
        cq.push_back(shadow[v.c_addr]);
        exp_c_rv = 1'b1;
      end
    end
    if (v.e_dgnt) begin
      if (v.d_we) shadow[v.d_addr] = v.d_wd;
      else begin
        dq.push_back(shadow[v.d_addr]);
        exp_d_rv = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    foreach (shadow[i]) shadow[i] = '0;
    exp_c_rv  = 1'b0;
    exp_d_rv  = 1'b0;
    last_c_rd = '0;
    last_d_rd = '0;

    //                 name            creq cwe ca  cwd            dreq dwe da  dwd           cg dg
    vecs_a.push_back(mk("rst_release",  1, 0,  0, 32'h0,          1, 0,  0, 32'h0,          1, 0));
    vecs_a.push_back(mk("dbg_pending",  0, 0,  0, 32'h0,          1, 0,  0, 32'h0,          0, 1));
    vecs_a.push_back(mk("cpu_wr10",     1, 1, 10, 32'h0000_0017,  0, 0,  0, 32'h0,          1, 0));
    vecs_a.push_back(mk("cpu_rd10",     1, 0, 10, 32'h0,          0, 0,  0, 32'h0,          1, 0));
    vecs_a.push_back(mk("dbg_wr1",      0, 0,  0, 32'h0,          1, 1,  1, 32'h11,         0, 1));
    vecs_a.push_back(mk("dbg_wr2",      0, 0,  0, 32'h0,          1, 1,  2, 32'h22,         0, 1));
    for (int i = 0; i < 6; i++)
      vecs_a.push_back(mk($sformatf("contend%0d", i), 1, 0, 1, 32'h0, 1, 0, 2, 32'h0,
                          ((i % 2) == 0), ((i % 2) == 1)));
    vecs_a.push_back(mk("dbg_wr31",     0, 0,  0, 32'h0,          1, 1, 31, 32'hDEAD_BEEF,  0, 1));
    vecs_a.push_back(mk("cpu_rd31",     1, 0, 31, 32'h0,          0, 0,  0, 32'h0,          1, 0));
    vecs_a.push_back(mk("dbg_wr5",      0, 0,  0, 32'h0,          1, 1,  5, 32'h55,         0, 1));
    vecs_a.push_back(mk("stall",        1, 0,  3, 32'h0,          1, 1,  7, 32'hA5A5_0007,  1, 0));
    vecs_a.push_back(mk("dbg_hold",     0, 0,  0, 32'h0,          1, 1,  7, 32'hA5A5_0007,  0, 1));
    vecs_a.push_back(mk("cpu_rd7",      1, 0,  7, 32'h0,          0, 0,  0, 32'h0,          1, 0));
    vecs_a.push_back(mk("idle",         0, 0,  0, 32'h0,          0, 0,  0, 32'h0,          0, 0));
    vecs_a.push_back(mk("after_idle",   1, 0,  1, 32'h0,          1, 0,  2, 32'h0,          0, 1));
    vecs_a.push_back(mk("flush_a",      0, 0,  0, 32'h0,          0, 0,  0, 32'h0,          0, 0));

    vecs_b.push_back(mk("post_rst",     1, 0, 10, 32'h0,          1, 0, 31, 32'h0,          1, 0));
    vecs_b.push_back(mk("post_rst_dbg", 0, 0,  0, 32'h0,          1, 0, 31, 32'h0,          0, 1));
    vecs_b.push_back(mk("flush_b",      0, 0,  0, 32'h0,          0, 0,  0, 32'h0,          0, 0));

    // Reset held with both reads pending.
    nreset   = 1'b0;
    cpu_req  = 1'b1; cpu_we = 1'b0; cpu_addr = '0; cpu_wd = '0;
    dbg_req  = 1'b1; dbg_we = 1'b0; dbg_addr = '0; dbg_wd = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk1("reset cpu_gnt", cpu_gnt, 1'b0);
    chk1("reset dbg_gnt", dbg_gnt, 1'b0);
    chk1("reset cpu_rvalid", cpu_rvalid, 1'b0);
    chk1("reset dbg_rvalid", dbg_rvalid, 1'b0);
    chk("reset cpu_rd", cpu_rd, '0);
    chk("reset dbg_rd", dbg_rd, '0);
    @(posedge clk);
    #1;
    nreset = 1'b1;

    foreach (vecs_a[i]) run_vec(vecs_a[i]);

    // Reset asserted after a read is granted but before its closing edge.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10;
    dbg_req = 1'b0;
    @(negedge clk);
    check_outputs("midrst_pre");
    chk1("midrst cpu_gnt", cpu_gnt, 1'b1);
    #2;
    nreset = 1'b0;
    #1;
    chk1("midrst gnt_gated", cpu_gnt, 1'b0);
    @(posedge clk);
    #1;
    chk1("midrst cpu_rvalid", cpu_rvalid, 1'b0);
    chk1("midrst dbg_rvalid", dbg_rvalid, 1'b0);
    chk("midrst cpu_rd", cpu_rd, '0);
    chk("midrst dbg_rd", dbg_rd, '0);
    cpu_req   = 1'b0;
    nreset    = 1'b1;
    exp_c_rv  = 1'b0;
    exp_d_rv  = 1'b0;
    last_c_rd = '0;
    last_d_rd = '0;
    cq.delete();
    dq.delete();

    foreach (vecs_b[i]) run_vec(vecs_b[i]);

    chk("cpu_queue_drained", DW'(cq.size()), '0);
    chk("dbg_queue_drained", DW'(dq.size()), '0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_data_mem_arbiter

// File: doc/data_mem_arbiter.md
# data_mem_arbiter

Shares the CPU's single-port 32-word data memory between two requesters: the CPU load/store path and a debug/loader port. The debug/loader port is used to preload and inspect data memory. The block holds the memory array, picks one access per cycle by round-robin, and returns read data one cycle later with a valid strobe. It sits between the CPU execute stage and the data RAM, replacing the CPU's direct data memory access.

## Interface
- DATA_WIDTH, 32, word width in bits
- ADDR_WIDTH, 5, word-address width; depth = 2**ADDR_WIDTH

- clk  in  1  single clock, all logic on rising edge
- nreset  in  1  reset, asynchronous assert and active-low; deassertion is synchronous to clk
- cpu_req  in  1  CPU access request; held until granted
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_WIDTH  word address
- cpu_wd  in  DATA_WIDTH  write data
- cpu_gnt  out  1  access accepted this cycle (combinational)
- cpu_stall  out  1  cpu_req & ~cpu_gnt
- cpu_rvalid  out  1  read data valid (registered)
- cpu_rd  out  DATA_WIDTH  read data (registered)
- dbg_req, dbg_we, dbg_addr, dbg_wd, dbg_gnt, dbg_rvalid, dbg_rd  same directions, widths and meaning as the cpu_* ports, for the debug/loader requester

## Operation
- Arbitration state is a 1-bit last_grant register, with values CPU or DBG.
  - Reset value: DBG, so the CPU wins the first contention.
- Per cycle:
  - Only cpu_req high: grant CPU.
  - Only dbg_req high: grant DBG.
  - Both high: grant the requester that is not last_grant.
  - Neither high: no grant, and last_grant is unchanged.
- On any grant, last_grant <= the granted requester at the next edge.
- At most one of cpu_gnt / dbg_gnt is high in any cycle.
- Granted write: mem[addr] <= wd at the closing edge. No rvalid is produced.
- Granted read: rd_q <= mem[addr] at the closing edge. rvalid is asserted for the granted requester only, for exactly one cycle.
- The non-granted requester's rd output holds its previous value.
- Requesters must hold req, we, addr and wd stable until gnt is seen. Dropping req before gnt is legal and cancels the request.
- Addresses are word addresses. Every value is in range, because depth = 2**ADDR_WIDTH.
- Memory contents are not reset. Simulation initializes them to 0.

## Timing
- Grant latency: 0 cycles, since gnt is combinational from req and last_grant.
- Read latency: 1 cycle. A read granted in cycle N gives rvalid and rd in cycle N+1.
- Back-to-back grants to one requester are allowed every cycle when the other is idle. Full throughput is 1 access per cycle.
- Under continuous contention, grants alternate CPU, DBG, CPU, and so on. Worst-case wait is 1 cycle.
- Write then read of the same address in consecutive cycles: the read returns the new data.
- Reset values:
  - cpu_gnt = dbg_gnt = 0 while nreset is low, so grants are gated by nreset.
  - cpu_rvalid = dbg_rvalid = 0.
  - cpu_rd = dbg_rd = 0.
  - last_grant = DBG.
- Reset asserted mid-operation: a pending read's rvalid is dropped. A write on the same edge as reset assertion is not guaranteed.

## Structure
- A shared cpu_pkg holds:
  - DATA_WIDTH and ADDR_WIDTH defaults
  - a requester enum (REQ_CPU, REQ_DBG) used for last_grant
  - word-address conversion constants (byte offset 2)
- One sub-module, data_spram: a single-port synchronous RAM with a write port and a registered read, parameterized by DATA_WIDTH and ADDR_WIDTH.
- The arbiter top-level contains:
  - the grant logic
  - the last_grant register
  - the request mux into data_spram
  - the per-requester rvalid/rd registers

## Test plan
- Reset: hold nreset low with both req high → both gnt = 0, both rvalid = 0, both rd = 0. Release nreset with both reads pending → CPU granted first.
- CPU alone: write 0x0000_0017 to addr 10, then read addr 10 → cpu_gnt high both cycles. cpu_rvalid high in the cycle after the read, with cpu_rd = 0x0000_0017. No dbg_rvalid.
- Contention: both request reads for 6 cycles (CPU addr 1, DBG addr 2, preloaded with 0x11 and 0x22) → grants alternate C,D,C,D,C,D. Each rvalid pulses the cycle after its own grant, with rd = 0x11 and 0x22 respectively.
- Cross-port coherency: DBG writes 0xDEAD_BEEF to addr 31 in cycle N, CPU reads addr 31 in cycle N+1 → cpu_rd = 0xDEAD_BEEF in cycle N+2.
- Stall and hold: DBG write pending while CPU wins → cpu_stall = 0, dbg not granted. The DBG write completes on the next cycle with unchanged data, and a CPU read of that address afterwards returns it.
- Reset mid-read: assert nreset low asynchronously between a granted read and its rvalid cycle → rvalid stays 0, last_grant = DBG. Memory retains the previously written data, checked by a read after release.
